ebpc_enc_scheduler: RTL and testbench

Shares one ebpc_encoder instance between N_CH independent activation streams. Grants the encoder to one requester for a whole stream (up to and including last), using round-robin selection. Holds the grant until the encoder reports block completion, so ZNZ/BPC output words are never interleaved between channels. Tags the active channel and reports per-stream word counts. Sits in front of ebpc_encoder, between the stream sources and the encoder's data_i/vld_i/rdy_o/last_i.

---
 rtl/ebpc_pkg.sv | 9 +
 rtl/ebpc_enc_scheduler_if.sv | 34 +++
 rtl/ebpc_rr_arb.sv | 28 ++
 rtl/ebpc_enc_scheduler.sv | 130 +++++++++++++
 tb/tb_ebpc_enc_scheduler.sv | 395 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ebpc_pkg.sv
// EBPC shared constants.
// Word width and encoder-scheduler sizing defaults.
package ebpc_pkg;

  localparam int unsigned DATA_W           = 8;
  localparam int unsigned EBPC_SCHED_N_CH  = 4;
  localparam int unsigned EBPC_SCHED_CNT_W = 16;

endpackage

// File: rtl/ebpc_enc_scheduler_if.sv
// Scheduler-to-encoder link: word handshake
// plus the encoder idle and block-done status.
interface ebpc_enc_scheduler_if
  import ebpc_pkg::*;
#(
  parameter int unsigned W = DATA_W
);

  logic [W-1:0] data;
  logic         last;
  logic         vld;
  logic         rdy;
  logic         idle;
  logic         blk_done;

  modport master (
    output data,
    output last,
    output vld,
    input  rdy,
    input  idle,
    input  blk_done
  );

  modport slave (
    input  data,
    input  last,
    input  vld,
    output rdy,
    output idle,
    output blk_done
  );

endinterface

// File: rtl/ebpc_rr_arb.sv
// Combinational round-robin pick: first set
// request at or after ptr, wrapping around.
module ebpc_rr_arb #(
  parameter  int unsigned N_CH = 4,
  localparam int unsigned ID_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] gnt_id,
  output logic            gnt_vld
);

  logic [ID_W-1:0] idx;

  always_comb begin
    gnt_id  = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      idx = ID_W'((32'(ptr) + i) % N_CH);
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx;
      end
    end
  end

endmodule

// File: rtl/ebpc_enc_scheduler.sv
// Shares one ebpc_encoder between N_CH streams,
// granting a whole stream at a time round-robin.
module ebpc_enc_scheduler
  import ebpc_pkg::*;
#(
  parameter  int unsigned N_CH  = EBPC_SCHED_N_CH,
  parameter  int unsigned CNT_W = EBPC_SCHED_CNT_W,
  localparam int unsigned ID_W  = $clog2(N_CH)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [N_CH-1:0]            ch_en_i,
  input  logic [N_CH-1:0][DATA_W-1:0] data_i,
  input  logic [N_CH-1:0]            last_i,
  input  logic [N_CH-1:0]            vld_i,
  output logic [N_CH-1:0]            rdy_o,
  ebpc_enc_scheduler_if.master       enc,
  output logic                       busy_o,
  output logic [ID_W-1:0]            ch_id_o,
  output logic                       done_o,
  output logic [ID_W-1:0]            done_id_o,
  output logic [CNT_W-1:0]           done_cnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_e;

  state_e state_q, state_d;

  logic [ID_W-1:0]  grant_q;
  logic [ID_W-1:0]  rr_ptr_q;
  logic [ID_W-1:0]  nxt_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic [ID_W-1:0]  done_id_q;
  logic [CNT_W-1:0] done_cnt_q;

  logic [N_CH-1:0] req;
  logic [ID_W-1:0] arb_id;
  logic            arb_vld;
  logic            pick;
  logic            hs;
  logic            hs_last;

  assign req = vld_i & ch_en_i;

  ebpc_rr_arb #(
    .N_CH (N_CH)
  ) u_arb (
    .req     (req),
    .ptr     (rr_ptr_q),
    .gnt_id  (arb_id),
    .gnt_vld (arb_vld)
  );

  assign pick    = (state_q == IDLE) && arb_vld && enc.idle;
  assign hs      = (state_q == STREAM) && vld_i[grant_q] && enc.rdy;
  assign hs_last = hs && last_i[grant_q];
  assign nxt_ptr = (grant_q == ID_W'(N_CH - 1)) ?
                   '0 : grant_q + ID_W'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick) state_d = STREAM;
      STREAM:  if (hs_last) state_d = DRAIN;
      DRAIN:   if (enc.blk_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pass-through is purely combinational so the
  // source sees the encoder's ready in-cycle.
  always_comb begin
    rdy_o    = '0;
    enc.data = '0;
    enc.last = 1'b0;
    enc.vld  = 1'b0;
    if (state_q == STREAM) begin
      enc.data       = data_i[grant_q];
      enc.last       = last_i[grant_q];
      enc.vld        = vld_i[grant_q];
      rdy_o[grant_q] = enc.rdy;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      done_id_q  <= '0;
      done_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (pick) begin
        grant_q <= arb_id;
        cnt_q   <= '0;
      end
      if (hs && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if ((state_q == DRAIN) && enc.blk_done) begin
        done_q     <= 1'b1;
        done_id_q  <= grant_q;
        done_cnt_q <= cnt_q;
        rr_ptr_q   <= nxt_ptr;
      end
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign ch_id_o    = grant_q;
  assign done_o     = done_q;
  assign done_id_o  = done_id_q;
  assign done_cnt_o = done_cnt_q;

endmodule

// File: tb/tb_ebpc_enc_scheduler.sv
// Directed bench for ebpc_enc_scheduler with
// per-channel stream sources and an encoder model.
module tb_ebpc_enc_scheduler;
  import ebpc_pkg::*;

  localparam int NC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst_n;
  logic [NC-1:0]            ch_en;
  logic [NC-1:0][DATA_W-1:0] data;
  logic [NC-1:0]            last;
  logic [NC-1:0]            vld;
  logic [NC-1:0]            rdy;
  logic                     busy;
  logic [1:0]               ch_id;
  logic                     done;
  logic [1:0]               done_id;
  logic [15:0]              done_cnt;

  ebpc_enc_scheduler_if enc_if ();

  ebpc_enc_scheduler #(
    .N_CH  (NC),
    .CNT_W (16)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .ch_en_i    (ch_en),
    .data_i     (data),
    .last_i     (last),
    .vld_i      (vld),
    .rdy_o      (rdy),
    .enc        (enc_if),
    .busy_o     (busy),
    .ch_id_o    (ch_id),
    .done_o     (done),
    .done_id_o  (done_id),
    .done_cnt_o (done_cnt)
  );

  int total = 0;
  int bad   = 0;

  int len[NC];
  int sent[NC];
  int stall_at[NC];
  int stall_left[NC];
  int done_len[NC];
  int gnt_q[$];
  int dq[$];
  int bd_pending;
  int hs_cnt    = 0;
  int rdy_cyc   = 0;
  int done_seen = 0;
  bit prev_done = 1'b0;

  task automatic drive();
    for (int c = 0; c < NC; c++) begin
      if (sent[c] < len[c] && stall_left[c] == 0) begin
        vld[c]  = 1'b1;
        data[c] = 8'(16 * (c + 1) + sent[c] + 1);
        last[c] = (sent[c] == len[c] - 1);
      end else begin
        vld[c]  = 1'b0;
        data[c] = 8'h00;
        last[c] = 1'b0;
      end
    end
  endtask

  task automatic clear_model();
    for (int c = 0; c < NC; c++) begin
      len[c]        = 0;
      sent[c]       = 0;
      stall_at[c]   = -1;
      stall_left[c] = 0;
    end
    gnt_q.delete();
    dq.delete();
    bd_pending      = 0;
    prev_done       = 1'b0;
    enc_if.rdy      = 1'b1;
    enc_if.idle     = 1'b1;
    enc_if.blk_done = 1'b0;
    drive();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    ch_en = 4'hF;
    clear_model();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic step();
    int cur;
    int e;
    bit hs;
    @(negedge clk);
    cur = (gnt_q.size() > 0) ? gnt_q[0] : -1;
    hs  = enc_if.vld && enc_if.rdy;
    if (rdy != 4'b0) begin
      rdy_cyc++;
      total++;
      if (cur < 0 || dq.size() != 0 || rdy !== 4'(1 << cur)) begin
        bad++;
        $display("FAIL rdy_grant: rdy=%b want ch %0d pending_done=%0d",
                 rdy, cur, dq.size());
      end
      total++;
      if (cur >= 0 && ch_id !== 2'(cur)) begin
        bad++;
        $display("FAIL ch_id: got %0d want %0d", ch_id, cur);
      end
    end
    if (hs) begin
      total++;
      if (cur < 0) begin
        bad++;
        $display("FAIL enc_word: handshake with no expected grant");
      end else if (enc_if.data !== 8'(16 * (cur + 1) + sent[cur] + 1) ||
                   enc_if.last !== (sent[cur] == len[cur] - 1)) begin
        bad++;
        $display("FAIL enc_word: got %h/%b want %h/%b", enc_if.data,
                 enc_if.last, 8'(16 * (cur + 1) + sent[cur] + 1),
                 (sent[cur] == len[cur] - 1));
      end
    end
    if (done) begin
      total++;
      if (prev_done) begin
        bad++;
        $display("FAIL done_pulse: done_o high 2 cycles, want 1");
      end
      total++;
      if (dq.size() == 0) begin
        bad++;
        $display("FAIL done_info: unexpected done id=%0d", done_id);
      end else begin
        e = dq.pop_front();
        if (done_id !== 2'(e) || done_cnt !== 16'(done_len[e])) begin
          bad++;
          $display("FAIL done_info: got id=%0d cnt=%0d want id=%0d cnt=%0d",
                   done_id, done_cnt, e, done_len[e]);
        end
      end
      done_seen++;
    end
    prev_done = done;
    @(posedge clk);
    #1;
    enc_if.blk_done = 1'b0;
    if (bd_pending > 0) begin
      bd_pending--;
      if (bd_pending == 0) enc_if.blk_done = 1'b1;
    end
    for (int c = 0; c < NC; c++)
      if (stall_left[c] > 0) stall_left[c]--;
    if (hs && cur >= 0) begin
      hs_cnt++;
      if (sent[cur] == len[cur] - 1) begin
        done_len[cur] = len[cur];
        len[cur]      = 0;
        sent[cur]     = 0;
        void'(gnt_q.pop_front());
        dq.push_back(cur);
        bd_pending = 2;
      end else begin
        sent[cur]++;
        if (sent[cur] == stall_at[cur]) begin
          stall_left[cur] = 10;
          stall_at[cur]   = -1;
        end
      end
    end
    enc_if.idle = (bd_pending == 0);
    drive();
  endtask

  task automatic run_until(input int target, input int budget);
    int n = 0;
    while (done_seen < target && n < budget) begin
      step();
      n++;
    end
    total++;
    if (done_seen < target) begin
      bad++;
      $display("FAIL timeout: dones=%0d want %0d", done_seen, target);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    total++;
    if ({rdy, enc_if.vld, enc_if.last, enc_if.data, busy, done,
         ch_id, done_id, done_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_out: rdy=%b vld=%b busy=%b done=%b cnt=%0d want 0",
               rdy, enc_if.vld, busy, done, done_cnt);
    end
  endtask

  task automatic test_single_ch();
    int h0 = hs_cnt;
    int d0 = done_seen;
    len[0] = 8;
    gnt_q.push_back(0);
    drive();
    run_until(d0 + 1, 60);
    repeat (3) step();
    total++;
    if (hs_cnt - h0 != 8) begin
      bad++;
      $display("FAIL single_hs: got %0d want 8", hs_cnt - h0);
    end
    total++;
    if (busy !== 1'b0 || done_seen != d0 + 1) begin
      bad++;
      $display("FAIL single_end: busy=%b dones=%0d want 0/%0d",
               busy, done_seen - d0, 1);
    end
  endtask

  task automatic test_all_four();
    int h0;
    int d0;
    apply_reset();
    h0 = hs_cnt;
    d0 = done_seen;
    for (int c = 0; c < NC; c++) begin
      len[c] = 3;
      gnt_q.push_back(c);
    end
    drive();
    run_until(d0 + 4, 200);
    total++;
    if (hs_cnt - h0 != 12) begin
      bad++;
      $display("FAIL all_four_hs: got %0d want 12", hs_cnt - h0);
    end
  endtask

  task automatic test_rr_ptr();
    int d0 = done_seen;
    len[2] = 2;
    gnt_q.push_back(2);
    drive();
    run_until(d0 + 1, 40);
    len[1] = 2;
    len[3] = 2;
    gnt_q.push_back(3);
    gnt_q.push_back(1);
    drive();
    run_until(d0 + 3, 80);
  endtask

  task automatic test_enable_mask();
    int h0 = hs_cnt;
    int d0 = done_seen;
    ch_en = 4'b1011;
    for (int c = 0; c < NC; c++) len[c] = 2;
    gnt_q.push_back(3);
    gnt_q.push_back(0);
    gnt_q.push_back(1);
    drive();
    run_until(d0 + 3, 120);
    repeat (20) step();
    total++;
    if (busy !== 1'b0 || done_seen != d0 + 3 || hs_cnt - h0 != 6) begin
      bad++;
      $display("FAIL enable_mask: busy=%b dones=%0d hs=%0d want 0/3/6",
               busy, done_seen - d0, hs_cnt - h0);
    end
    ch_en  = 4'hF;
    len[2] = 0;
    drive();
  endtask

  task automatic test_stall();
    int h0 = hs_cnt;
    int d0 = done_seen;
    len[1]      = 5;
    stall_at[1] = 2;
    gnt_q.push_back(1);
    gnt_q.push_back(0);
    drive();
    repeat (3) step();
    len[0] = 3;
    drive();
    run_until(d0 + 2, 120);
    total++;
    if (hs_cnt - h0 != 8) begin
      bad++;
      $display("FAIL stall_hs: got %0d want 8", hs_cnt - h0);
    end
  endtask

  task automatic test_stray_blk_done();
    int d0 = done_seen;
    enc_if.blk_done = 1'b1;
    @(posedge clk);
    #1 enc_if.blk_done = 1'b0;
    repeat (3) step();
    total++;
    if (done_seen != d0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL stray_blk_done: dones=%0d busy=%b want 0/0",
               done_seen - d0, busy);
    end
  endtask

  task automatic test_single_word();
    int h0 = hs_cnt;
    int r0 = rdy_cyc;
    int d0 = done_seen;
    len[3] = 1;
    gnt_q.push_back(3);
    drive();
    run_until(d0 + 1, 30);
    total++;
    if (hs_cnt - h0 != 1 || rdy_cyc - r0 != 1) begin
      bad++;
      $display("FAIL single_word: hs=%0d stream_cyc=%0d want 1/1",
               hs_cnt - h0, rdy_cyc - r0);
    end
  endtask

  task automatic test_midstream_reset();
    int d0;
    int n = 0;
    len[0] = 2;
    gnt_q.push_back(0);
    drive();
    run_until(done_seen + 1, 30);
    len[2] = 8;
    gnt_q.push_back(2);
    drive();
    while (sent[2] < 3 && n < 30) begin
      step();
      n++;
    end
    d0 = done_seen;
    rst_n = 1'b0;
    #1;
    total++;
    if ({rdy, enc_if.vld, enc_if.last, enc_if.data, busy, done,
         ch_id, done_id, done_cnt} !== '0 || sent[2] != 3) begin
      bad++;
      $display("FAIL midreset_out: rdy=%b vld=%b busy=%b id=%0d sent=%0d want 0",
               rdy, enc_if.vld, busy, ch_id, sent[2]);
    end
    clear_model();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) step();
    total++;
    if (done_seen != d0) begin
      bad++;
      $display("FAIL midreset_done: got %0d dones want 0", done_seen - d0);
    end
    len[0] = 2;
    len[3] = 2;
    gnt_q.push_back(0);
    gnt_q.push_back(3);
    drive();
    run_until(d0 + 2, 80);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_ch();
    test_all_four();
    test_rr_ptr();
    test_enable_mask();
    test_stall();
    test_stray_blk_done();
    test_single_word();
    test_midstream_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
